// File: rtl/serial_pow2_signed_divider.sv
// Serial signed divide-by-2^sh: one arithmetic-right-shift step per cycle over valid/ready handshakes.
// Define SERIAL_POW2_DIV_ROUND_TO_ZERO_EN for round-toward-zero results; default is floor (>>>).
module serial_pow2_signed_divider #(
    parameter int N  = 8,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] sh,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // N always fits in SW bits because 2^SW > N.
    localparam logic [SW-1:0] N_K = SW'(N);

    state_t        state, state_nxt;
    logic [N-1:0]  work;
    logic [N-1:0]  shifted;
    logic [N-1:0]  res_nxt;
    logic [SW-1:0] cnt;
    logic [SW-1:0] k;
    logic          accept;
    logic          last;

    assign k       = (sh >= N_K) ? N_K : sh;
    assign shifted = {work[N-1], work[N-1:1]};
    assign last    = (cnt == SW'(1));

`ifdef SERIAL_POW2_DIV_ROUND_TO_ZERO_EN
    logic sticky;
    logic sticky_out;

    // A negative value that lost any 1 bit is bumped up by one to truncate toward zero.
    assign sticky_out = sticky | work[0];
    assign res_nxt    = shifted + {{(N-1){1'b0}}, shifted[N-1] & sticky_out};
`else
    assign res_nxt = shifted;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        arg_rdy   = 1'b0;
        res_vld   = 1'b0;
        accept    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                arg_rdy = 1'b1;
                if (arg_vld) begin
                    accept    = 1'b1;
                    state_nxt = (k == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                res_vld = 1'b1;
                if (res_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            res  <= '0;
`ifdef SERIAL_POW2_DIV_ROUND_TO_ZERO_EN
            sticky <= 1'b0;
`endif
        end else if (accept) begin
            work <= a;
            cnt  <= k;
`ifdef SERIAL_POW2_DIV_ROUND_TO_ZERO_EN
            sticky <= 1'b0;
`endif
            if (k == '0) res <= a;
        end else if (state == SHIFT) begin
            work <= shifted;
            cnt  <= cnt - SW'(1);
`ifdef SERIAL_POW2_DIV_ROUND_TO_ZERO_EN
            sticky <= sticky_out;
`endif
            if (last) res <= res_nxt;
        end
    end

endmodule

// File: tb/tb_serial_pow2_signed_divider.sv
// Scoreboard bench for serial_pow2_signed_divider: directed vectors plus a random back-to-back run.
// Expected values follow SERIAL_POW2_DIV_ROUND_TO_ZERO_EN when it is defined.
module tb_serial_pow2_signed_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arg_vld = 1'b0;
    logic       arg_rdy;
    logic [7:0] a = '0;
    logic [3:0] sh = '0;
    logic       res_vld;
    logic       res_rdy = 1'b1;
    logic [7:0] res;
    logic       busy;

    typedef struct {
        logic [7:0] exp;
        int         lat;
    } sb_t;

    sb_t q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  acc_cyc = 0;
    bit  rr_mode = 1'b0;
    bit  prev_vld = 1'b0;

    serial_pow2_signed_divider #(.N(8), .SW(4)) dut (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg_rdy(arg_rdy),
        .a(a), .sh(sh), .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rr_mode) res_rdy = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [7:0] model(input logic [7:0] av, input logic [3:0] shv);
        int x;
        int kk;
        x  = int'($signed(av));
        kk = (shv >= 4'd8) ? 8 : int'(shv);
`ifdef SERIAL_POW2_DIV_ROUND_TO_ZERO_EN
        x = x / (1 << kk);
`else
        x = x >>> kk;
`endif
        return x[7:0];
    endfunction

    task automatic issue(input logic [7:0] av, input logic [3:0] shv, input logic [7:0] expv);
        sb_t e;
        int  g;
        e.exp = expv;
        e.lat = ((shv >= 4'd8) ? 8 : int'(shv)) + 1;
        q.push_back(e);
        a = av;
        sh = shv;
        arg_vld = 1'b1;
        g = 0;
        @(negedge clk);
        while (!arg_rdy && g < 400) begin
            step();
            @(negedge clk);
            g++;
        end
        if (!arg_rdy) report_fail("accept_timeout");
        else acc_cyc = cyc;
        step();
        arg_vld = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 4000) begin
            step();
            g++;
        end
        if (q.size() != 0) begin
            report_fail("drain_timeout");
            q.delete();
        end
    endtask

    // Monitor: latency at the rising edge of res_vld, value at each result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (res_vld && !prev_vld) begin
                if (q.size() == 0) report_fail("spurious_res_vld");
                else check("latency", 32'(cyc - acc_cyc), 32'(q[0].lat));
            end
            if (res_vld && res_rdy) begin
                if (q.size() == 0) report_fail("duplicate_result");
                else check("res", {24'd0, res}, {24'd0, q.pop_front().exp});
            end
            prev_vld = res_vld;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] av;
        logic [3:0] shv;
        logic [7:0] floor_v;
        logic [7:0] rtz_v;
    } vec_t;

    vec_t dir[8];

    initial begin
        dir[0] = '{8'h64, 4'd3,  8'h0C, 8'h0C};  // 100/8
        dir[1] = '{8'hF9, 4'd1,  8'hFC, 8'hFD};  // -7/2
        dir[2] = '{8'h80, 4'd9,  8'hFF, 8'h00};  // clamp to 8
        dir[3] = '{8'h80, 4'd7,  8'hFF, 8'hFF};  // -128/128 exact
        dir[4] = '{8'h81, 4'd2,  8'hE0, 8'hE1};  // -127/4
        dir[5] = '{8'h7F, 4'd8,  8'h00, 8'h00};
        dir[6] = '{8'h01, 4'd15, 8'h00, 8'h00};
        dir[7] = '{8'hFF, 4'd1,  8'hFF, 8'h00};  // -1/2

        #3;
        check("rst_res_vld", {31'd0, res_vld}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res", {24'd0, res}, 32'd0);
        check("rst_arg_rdy", {31'd0, arg_rdy}, 32'd1);
        #10 rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
`ifdef SERIAL_POW2_DIV_ROUND_TO_ZERO_EN
            issue(dir[i].av, dir[i].shv, dir[i].rtz_v);
`else
            issue(dir[i].av, dir[i].shv, dir[i].floor_v);
`endif
            drain();
            if (i == 1) begin
                // Reset mid-SHIFT while res still holds the previous nonzero result.
                a = 8'h80;
                sh = 4'd5;
                arg_vld = 1'b1;
                step();
                arg_vld = 1'b0;
                step();
                step();
                check("mid_busy_before", {31'd0, busy}, 32'd1);
                #2 rst_n = 1'b0;
                #1;
                check("mid_rst_res_vld", {31'd0, res_vld}, 32'd0);
                check("mid_rst_res", {24'd0, res}, 32'd0);
                check("mid_rst_busy", {31'd0, busy}, 32'd0);
                step();
                rst_n = 1'b1;
                step();
                check("mid_rel_arg_rdy", {31'd0, arg_rdy}, 32'd1);
                check("mid_rel_busy", {31'd0, busy}, 32'd0);
            end
        end

        // sh = 0 with five cycles of backpressure and ignored argument pulses.
        res_rdy = 1'b0;
        issue(8'hA5, 4'd0, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res_vld", {31'd0, res_vld}, 32'd1);
            check("bp_res", {24'd0, res}, 32'hA5);
            check("bp_arg_rdy", {31'd0, arg_rdy}, 32'd0);
            step();
            arg_vld = (i % 2 == 0);
            a = 8'h33;
            sh = 4'd2;
        end
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        step();
        @(negedge clk);
        check("bp_rel_arg_rdy", {31'd0, arg_rdy}, 32'd1);
        check("bp_rel_res_vld", {31'd0, res_vld}, 32'd0);
        check("bp_queue_empty", 32'(q.size()), 32'd0);
        step();

        rr_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] av;
            logic [3:0] shv;
            av  = 8'($urandom);
            shv = 4'($urandom_range(0, 15));
            issue(av, shv, model(av, shv));
        end
        drain();
        rr_mode = 1'b0;
        res_rdy = 1'b1;
        step();
        step();
        check("final_idle", {30'd0, busy, res_vld}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
